// File: rtl/audio_pkg.sv
// Shared constants and types for the frame-synchronous audio mixer.
package audio_pkg;

   localparam int FRAME_DEFAULT = 512;
   localparam int VOL_UNITY     = 8;
   localparam int SAMPLE_W      = 16;
   localparam int VOL_W         = 4;
   // Signed sample times zero-extended gain: 16 + 4 + 1 sign bit.
   localparam int PROD_W        = SAMPLE_W + VOL_W + 1;

   localparam int SAMPLE_MAX    = 32767;
   localparam int SAMPLE_MIN    = -32768;

   typedef enum logic [1:0] {
      IDLE,
      ACC,
      SAT,
      DONE
   } state_t;

   typedef enum logic {
      SIDE_L,
      SIDE_R
   } side_t;

endpackage

// File: rtl/audio_mac_sat.sv
// Shared multiply-accumulate with separate left/right accumulators, plus the
// combinational shift-and-clamp stage that turns each accumulator into a
// 16-bit sample and a clip flag.
module audio_mac_sat
   import audio_pkg::*;
#(
   parameter int ACC_W     = PROD_W + 2,
   parameter int VOL_SHIFT = 3
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       clr,
   input  logic                       en,
   input  side_t                      side,
   input  logic signed [SAMPLE_W-1:0] sample,
   input  logic        [VOL_W-1:0]    vol,
   input  logic                       mute,
   output logic signed [SAMPLE_W-1:0] sat_l,
   output logic signed [SAMPLE_W-1:0] sat_r,
   output logic                       clip_l,
   output logic                       clip_r
);

   logic signed [PROD_W-1:0] sample_ext;
   logic signed [PROD_W-1:0] vol_ext;
   logic signed [PROD_W-1:0] product;
   logic signed [ACC_W-1:0]  acc_l;
   logic signed [ACC_W-1:0]  acc_r;

   // Single shared multiplier: sign-extended sample times non-negative gain.
   always_comb begin
      sample_ext = PROD_W'(sample);
      vol_ext    = PROD_W'({1'b0, vol});
      product    = mute ? '0 : sample_ext * vol_ext;
   end

   // Accumulate the current product into the side selected by the sequencer.
   always_ff @(posedge clock) begin
      if (reset) begin
         acc_l <= '0;
         acc_r <= '0;
      end else if (clr) begin
         acc_l <= '0;
         acc_r <= '0;
      end else if (en) begin
         if (side == SIDE_L) acc_l <= acc_l + ACC_W'(product);
         else                acc_r <= acc_r + ACC_W'(product);
      end
   end

   // Arithmetic shift back to sample scale, then clamp; MSB of result is the clip flag.
   function automatic logic [SAMPLE_W:0] clamp(input logic signed [ACC_W-1:0] acc);
      logic signed [ACC_W-1:0] m;
      m = acc >>> VOL_SHIFT;
      if (m > ACC_W'(SAMPLE_MAX))      clamp = {1'b1, SAMPLE_W'(SAMPLE_MAX)};
      else if (m < ACC_W'(SAMPLE_MIN)) clamp = {1'b1, SAMPLE_W'(SAMPLE_MIN)};
      else                             clamp = {1'b0, m[SAMPLE_W-1:0]};
   endfunction

   assign {clip_l, sat_l} = clamp(acc_l);
   assign {clip_r, sat_r} = clamp(acc_r);

endmodule

// File: rtl/audio_mix_sched.sv
// Frame-synchronous stereo mixer: snapshots all sources at frame start,
// sequences one MAC over every channel/side, saturates into staging, and
// commits staging to l/r only at the next frame boundary.
module audio_mix_sched
   import audio_pkg::*;
#(
   parameter int CHANNELS  = 4,
   parameter int FRAME     = FRAME_DEFAULT,
   parameter int VOL_SHIFT = 3
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [SAMPLE_W*CHANNELS-1:0]  src_l,
   input  logic [SAMPLE_W*CHANNELS-1:0]  src_r,
   input  logic [VOL_W*CHANNELS-1:0]     vol,
   input  logic [CHANNELS-1:0]           mute,
   output logic signed [SAMPLE_W-1:0]    l,
   output logic signed [SAMPLE_W-1:0]    r,
   output logic                          frame,
   output logic                          clip_l,
   output logic                          clip_r,
   output logic                          busy
);

   localparam int FC_W  = $clog2(FRAME);
   localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int ACC_W = PROD_W + $clog2(CHANNELS);

   // The mix sequence must finish well inside one frame, or commits would tear.
   if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
      $error("audio_mix_sched: CHANNELS must be 1..8");
   end
   if (2 * CHANNELS + 2 >= FRAME) begin : g_bad_frame
      $error("audio_mix_sched: 2*CHANNELS+2 must be less than FRAME");
   end

   logic [FC_W-1:0]                     fc;
   logic                                frame_start;

   logic [CHANNELS-1:0][SAMPLE_W-1:0]   snap_l;
   logic [CHANNELS-1:0][SAMPLE_W-1:0]   snap_r;
   logic [CHANNELS-1:0][VOL_W-1:0]      snap_vol;
   logic [CHANNELS-1:0]                 snap_mute;

   state_t                              state, state_next;
   side_t                               side, side_next;
   logic [CH_W-1:0]                     ch, ch_next;
   logic                                clr, en, stg_we;

   logic signed [SAMPLE_W-1:0]          mac_sample;
   logic signed [SAMPLE_W-1:0]          sat_l, sat_r;
   logic                                sat_clip_l, sat_clip_r;
   logic signed [SAMPLE_W-1:0]          stg_l, stg_r;
   logic                                stg_clip_l, stg_clip_r;

   assign frame_start = (fc == '0) && !reset;
   assign frame       = frame_start;
   assign busy        = (state != IDLE);

   // Free-running frame counter, wrapping FRAME-1 -> 0.
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples pre-edge values, independent of block ordering.
      if (reset)                          fc <= '0;
      else if (fc == FC_W'(FRAME - 1))    fc <= '0;
      else                                fc <= fc + FC_W'(1);
   end

   // Frame boundary: commit old staging and snapshot new inputs in the same cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         snap_l    <= '0;
         snap_r    <= '0;
         snap_vol  <= '0;
         snap_mute <= '0;
         l         <= '0;
         r         <= '0;
         clip_l    <= 1'b0;
         clip_r    <= 1'b0;
      end else if (frame_start) begin
         snap_l    <= src_l;
         snap_r    <= src_r;
         snap_vol  <= vol;
         snap_mute <= mute;
         l         <= stg_l;
         r         <= stg_r;
         clip_l    <= stg_clip_l;
         clip_r    <= stg_clip_r;
      end
   end

   // Sequencer state, channel index and side register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         ch    <= '0;
         side  <= SIDE_L;
      end else begin
         state <= state_next;
         ch    <= ch_next;
         side  <= side_next;
      end
   end

   // Next-state and MAC control: ch0 L, ch0 R, ch1 L, ... then saturate.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves one
      // unassigned, which would otherwise infer a latch.
      state_next = state;
      ch_next    = ch;
      side_next  = side;
      clr        = 1'b0;
      en         = 1'b0;
      stg_we     = 1'b0;
      case (state)
         IDLE: begin
            if (frame_start) begin
               state_next = ACC;
               clr        = 1'b1;
               ch_next    = '0;
               side_next  = SIDE_L;
            end
         end
         ACC: begin
            en = 1'b1;
            if (side == SIDE_L) begin
               side_next = SIDE_R;
            end else begin
               side_next = SIDE_L;
               if (ch == CH_W'(CHANNELS - 1)) state_next = SAT;
               else                           ch_next    = ch + CH_W'(1);
            end
         end
         SAT: begin
            stg_we     = 1'b1;
            state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Operand select from the frame snapshot.
   always_comb begin
      mac_sample = (side == SIDE_L) ? snap_l[ch] : snap_r[ch];
   end

   audio_mac_sat #(
      .ACC_W     (ACC_W),
      .VOL_SHIFT (VOL_SHIFT)
   ) u_mac (
      .clock  (clock),
      .reset  (reset),
      .clr    (clr),
      .en     (en),
      .side   (side),
      .sample (mac_sample),
      .vol    (snap_vol[ch]),
      .mute   (snap_mute[ch]),
      .sat_l  (sat_l),
      .sat_r  (sat_r),
      .clip_l (sat_clip_l),
      .clip_r (sat_clip_r)
   );

   // Staging is written only in SAT, so the frame-boundary commit never sees a partial mix.
   always_ff @(posedge clock) begin
      if (reset) begin
         stg_l      <= '0;
         stg_r      <= '0;
         stg_clip_l <= 1'b0;
         stg_clip_r <= 1'b0;
      end else if (stg_we) begin
         stg_l      <= sat_l;
         stg_r      <= sat_r;
         stg_clip_l <= sat_clip_l;
         stg_clip_r <= sat_clip_r;
      end
   end

endmodule

// File: tb/tb_audio_mix_sched.sv
// Self-checking bench for audio_mix_sched: directed cases, timing, reset
// abort, and randomized frames compared against an arithmetic mix model.
module tb_audio_mix_sched;

   localparam int CH    = 4;
   localparam int FRAME = 512;
   localparam int NRAND = 20;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic [16*CH-1:0]  src_l = '0;
   logic [16*CH-1:0]  src_r = '0;
   logic [4*CH-1:0]   vol   = '0;
   logic [CH-1:0]     mute  = '0;
   logic [15:0]       l, r;
   logic              frame, clip_l, clip_r, busy;

   int n_cmp = 0;
   int n_bad = 0;

   // Per-channel configuration the bench intends to mix.
   int s_l [CH];
   int s_r [CH];
   int v   [CH];
   bit m   [CH];

   always #5 clock = ~clock;

   audio_mix_sched #(
      .CHANNELS  (CH),
      .FRAME     (FRAME),
      .VOL_SHIFT (3)
   ) dut (
      .clock  (clock),
      .reset  (reset),
      .src_l  (src_l),
      .src_r  (src_r),
      .vol    (vol),
      .mute   (mute),
      .l      (l),
      .r      (r),
      .frame  (frame),
      .clip_l (clip_l),
      .clip_r (clip_r),
      .busy   (busy)
   );

   initial begin
      #(2000000);
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   // Reference: sum of sample*gain over unmuted channels, divide by 8 rounding
   // toward minus infinity, clamp to the 16-bit range.
   function automatic void model(output logic [15:0] el, output logic [15:0] er,
                                 output logic ecl, output logic ecr);
      int al = 0;
      int ar = 0;
      int ml, mr;
      for (int i = 0; i < CH; i++) begin
         if (!m[i]) begin
            al += s_l[i] * v[i];
            ar += s_r[i] * v[i];
         end
      end
      ml = (al >= 0) ? al / 8 : -((-al + 7) / 8);
      mr = (ar >= 0) ? ar / 8 : -((-ar + 7) / 8);
      ecl = (ml > 32767) || (ml < -32768);
      ecr = (mr > 32767) || (mr < -32768);
      if (ml > 32767) ml = 32767;
      if (ml < -32768) ml = -32768;
      if (mr > 32767) mr = 32767;
      if (mr < -32768) mr = -32768;
      el = 16'(ml);
      er = 16'(mr);
   endfunction

   task automatic apply();
      for (int i = 0; i < CH; i++) begin
         src_l[16*i +: 16] = 16'(s_l[i]);
         src_r[16*i +: 16] = 16'(s_r[i]);
         vol[4*i +: 4]     = 4'(v[i]);
         mute[i]           = m[i];
      end
   endtask

   task automatic scramble();
      for (int i = 0; i < CH; i++) begin
         src_l[16*i +: 16] = 16'($urandom);
         src_r[16*i +: 16] = 16'($urandom);
         vol[4*i +: 4]     = 4'($urandom);
         mute[i]           = 1'($urandom);
      end
   endtask

   task automatic clear_cfg();
      for (int i = 0; i < CH; i++) begin
         s_l[i] = int'($urandom_range(0, 65535)) - 32768;
         s_r[i] = int'($urandom_range(0, 65535)) - 32768;
         v[i]   = int'($urandom_range(0, 15));
         m[i]   = 1'b1;
      end
   endtask

   // Advance to the next falling edge where the frame strobe is high.
   task automatic wait_strobe();
      bit seen = 1'b0;
      for (int k = 0; k < 2 * FRAME && !seen; k++) begin
         @(negedge clock);
         if (frame === 1'b1) seen = 1'b1;
      end
      if (!seen) begin
         n_cmp++;
         n_bad++;
         $display("FAIL strobe_timeout: no frame strobe within %0d clocks, required one", 2 * FRAME);
      end
   endtask

   // Snapshot the configured inputs, disturb them mid-frame, and return just
   // after the commit one frame later.
   task automatic mix_frame();
      wait_strobe();
      apply();
      @(posedge clock);
      @(negedge clock);
      scramble();
      wait_strobe();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clock);
      n_cmp++;
      if ({l, r, clip_l, clip_r} !== 34'd0) begin
         n_bad++;
         $display("FAIL reset_outputs: got l=%h r=%h cl=%b cr=%b, required all zero", l, r, clip_l, clip_r);
      end
      n_cmp++;
      if ({busy, frame} !== 2'b00) begin
         n_bad++;
         $display("FAIL reset_busy_frame: got busy=%b frame=%b, required 0 0", busy, frame);
      end
      reset = 1'b0;
      #1;
      n_cmp++;
      if (frame !== 1'b1) begin
         n_bad++;
         $display("FAIL release_frame: got frame=%b, required 1", frame);
      end
   endtask

   task automatic test_unity();
      clear_cfg();
      s_l[0] = 32'sh1234;
      s_r[0] = -4660;
      v[0]   = 8;
      m[0]   = 1'b0;
      mix_frame();
      n_cmp++;
      if ({l, r, clip_l, clip_r} !== {16'h1234, 16'hEDCC, 2'b00}) begin
         n_bad++;
         $display("FAIL unity: got l=%h r=%h cl=%b cr=%b, required 1234 edcc 0 0", l, r, clip_l, clip_r);
      end
   endtask

   task automatic test_pos_sat();
      clear_cfg();
      for (int i = 0; i < 2; i++) begin
         s_l[i] = 32'sh7000;
         s_r[i] = 32'sh0100;
         v[i]   = 8;
         m[i]   = 1'b0;
      end
      mix_frame();
      n_cmp++;
      if ({l, r, clip_l, clip_r} !== {16'h7FFF, 16'h0200, 2'b10}) begin
         n_bad++;
         $display("FAIL pos_sat: got l=%h r=%h cl=%b cr=%b, required 7fff 0200 1 0", l, r, clip_l, clip_r);
      end
   endtask

   task automatic test_neg_sat_gain();
      clear_cfg();
      s_l[0] = -32768;
      s_r[0] = 0;
      v[0]   = 15;
      m[0]   = 1'b0;
      mix_frame();
      n_cmp++;
      if ({l, r, clip_l, clip_r} !== {16'h8000, 16'h0000, 2'b10}) begin
         n_bad++;
         $display("FAIL neg_sat: got l=%h r=%h cl=%b cr=%b, required 8000 0000 1 0", l, r, clip_l, clip_r);
      end
      s_l[0] = 32'sh0800;
      v[0]   = 4;
      mix_frame();
      n_cmp++;
      if ({l, clip_l} !== {16'h0400, 1'b0}) begin
         n_bad++;
         $display("FAIL half_gain: got l=%h cl=%b, required 0400 0", l, clip_l);
      end
   endtask

   task automatic test_mute_zero();
      for (int i = 0; i < CH; i++) begin
         s_l[i] = 32767;
         s_r[i] = 32767;
         v[i]   = 15;
         m[i]   = 1'b1;
      end
      mix_frame();
      n_cmp++;
      if ({l, r, clip_l, clip_r} !== 34'd0) begin
         n_bad++;
         $display("FAIL all_muted: got l=%h r=%h cl=%b cr=%b, required all zero", l, r, clip_l, clip_r);
      end
      for (int i = 0; i < CH; i++) begin
         v[i] = 0;
         m[i] = 1'b0;
      end
      mix_frame();
      n_cmp++;
      if ({l, r, clip_l, clip_r} !== 34'd0) begin
         n_bad++;
         $display("FAIL zero_vol: got l=%h r=%h cl=%b cr=%b, required all zero", l, r, clip_l, clip_r);
      end
   endtask

   task automatic test_timing();
      int period = 0;
      int busy_cycles = 0;
      int viol = 0;
      int changes = 0;
      logic [15:0] prev_l;
      logic prev_f;
      wait_strobe();
      do begin
         @(negedge clock);
         period++;
         if (busy === 1'b1) busy_cycles++;
      end while (frame !== 1'b1 && period < 2 * FRAME);
      n_cmp++;
      if (period != FRAME) begin
         n_bad++;
         $display("FAIL frame_period: got %0d clocks, required %0d", period, FRAME);
      end
      n_cmp++;
      if (busy_cycles != 2 * CH + 2) begin
         n_bad++;
         $display("FAIL busy_cycles: got %0d, required %0d", busy_cycles, 2 * CH + 2);
      end
      // Watch l across several commits while feeding a new random mix each frame.
      prev_l = l;
      prev_f = frame;
      for (int k = 0; k < 3 * FRAME + 4; k++) begin
         if (frame === 1'b1) begin
            for (int i = 0; i < CH; i++) begin
               s_l[i] = int'($urandom_range(0, 65535)) - 32768;
               s_r[i] = int'($urandom_range(0, 65535)) - 32768;
               v[i]   = int'($urandom_range(1, 15));
               m[i]   = 1'b0;
            end
            apply();
         end
         @(negedge clock);
         if (l !== prev_l) begin
            changes++;
            if (!prev_f) viol++;
         end
         prev_l = l;
         prev_f = frame;
      end
      n_cmp++;
      if (viol != 0) begin
         n_bad++;
         $display("FAIL l_change_off_strobe: got %0d changes outside strobe cycles, required 0", viol);
      end
      n_cmp++;
      if (changes < 1) begin
         n_bad++;
         $display("FAIL l_updates: got %0d changes, required at least 1", changes);
      end
   endtask

   task automatic test_random();
      logic [15:0] el, er;
      logic ecl, ecr;
      for (int t = 0; t < NRAND; t++) begin
         for (int i = 0; i < CH; i++) begin
            if (t % 4 == 3) s_l[i] = ($urandom_range(0, 1) != 0) ? 32767 : -32768;
            else            s_l[i] = int'($urandom_range(0, 65535)) - 32768;
            s_r[i] = int'($urandom_range(0, 65535)) - 32768;
            v[i]   = int'($urandom_range(0, 15));
            m[i]   = ($urandom_range(0, 3) == 0);
         end
         model(el, er, ecl, ecr);
         mix_frame();
         n_cmp++;
         if ({l, r, clip_l, clip_r} !== {el, er, ecl, ecr}) begin
            n_bad++;
            $display("FAIL random_%0d: got l=%h r=%h cl=%b cr=%b, required l=%h r=%h cl=%b cr=%b",
                     t, l, r, clip_l, clip_r, el, er, ecl, ecr);
         end
      end
   endtask

   task automatic test_reset_mid_acc();
      clear_cfg();
      s_l[0] = 32'sh1234;
      s_r[0] = -4660;
      v[0]   = 8;
      m[0]   = 1'b0;
      mix_frame();
      n_cmp++;
      if ({l, r} !== {16'h1234, 16'hEDCC}) begin
         n_bad++;
         $display("FAIL pre_reset_mix: got l=%h r=%h, required 1234 edcc", l, r);
      end
      wait_strobe();
      apply();
      repeat (3) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      n_cmp++;
      if ({l, r, busy} !== 33'd0) begin
         n_bad++;
         $display("FAIL mid_acc_reset: got l=%h r=%h busy=%b, required 0 0 0", l, r, busy);
      end
      @(negedge clock);
      reset = 1'b0;
      #1;
      n_cmp++;
      if ({frame, busy} !== 2'b10) begin
         n_bad++;
         $display("FAIL fc_restart: got frame=%b busy=%b, required 1 0", frame, busy);
      end
      @(posedge clock);
      #1;
      n_cmp++;
      if ({l, r, clip_l, clip_r} !== 34'd0) begin
         n_bad++;
         $display("FAIL first_commit_zero: got l=%h r=%h cl=%b cr=%b, required all zero", l, r, clip_l, clip_r);
      end
      wait_strobe();
      @(posedge clock);
      #1;
      n_cmp++;
      if ({l, r} !== {16'h1234, 16'hEDCC}) begin
         n_bad++;
         $display("FAIL second_strobe_mix: got l=%h r=%h, required 1234 edcc", l, r);
      end
   endtask

   initial begin
      test_reset();
      test_unity();
      test_pos_sat();
      test_neg_sat_gain();
      test_mute_zero();
      test_timing();
      test_random();
      test_reset_mid_acc();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
